// File: rtl/gray_sequence_checker.sv
// Gray code sequence checker: decodes Gray samples, tracks lock on +1 steps.
// Optional saturating error counter enabled by macro GRAY_CHK_ERR_CNT_EN.
module gray_sequence_checker #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gray_in_valid,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             locked,
   output logic             seq_err,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {
      IDLE,
      ACQ,
      LOCK
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] bin_dec;
   logic [WIDTH-1:0] ref_inc;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       cnt_inc;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             legal;

   // Gray to binary: each bit is the XOR of itself and all higher Gray bits
   always_comb begin
      bin_dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_dec[i] = ^(gray_in >> i);
      end
   end

   assign ref_inc = ref_q + WIDTH'(1);
   assign legal   = (bin_dec == ref_inc);
   assign cnt_inc = cnt_q + 4'd1;

   // Next-state and output decode; idle cycles clear the strobes only
   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      if (gray_in_valid) begin
         ref_d = bin_dec;
         bin_d = bin_dec;
         vld_d = 1'b1;
         unique case (state_q)
            IDLE: begin
               cnt_d   = 4'd0;
               state_d = ACQ;
            end
            ACQ: begin
               if (legal) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= 4'(LOCK_CNT)) begin
                     state_d = LOCK;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
            LOCK: begin
               if (!legal) begin
                  err_d   = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = ACQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ref_q   <= '0;
         cnt_q   <= 4'd0;
         bin_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = vld_q;
   assign seq_err   = err_q;
   assign locked    = (state_q == LOCK);

`ifdef GRAY_CHK_ERR_CNT_EN
   logic [7:0] ecnt_q, ecnt_d;

   // Saturating count, stepped on the edge that raises seq_err
   always_comb begin
      ecnt_d = ecnt_q;
      if (err_d && (ecnt_q != 8'hFF)) begin
         ecnt_d = ecnt_q + 8'd1;
      end
   end

   // Error counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ecnt_q <= 8'd0;
      end else begin
         ecnt_q <= ecnt_d;
      end
   end

   assign err_count = ecnt_q;
`else
   assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_gray_sequence_checker.sv
// Scoreboard bench for gray_sequence_checker (WIDTH=3, LOCK_CNT=2).
// Driver queues hand-computed responses; a negedge monitor checks them.
module tb_gray_sequence_checker;

   typedef struct packed {
      logic [2:0] b;
      logic       l;
      logic       e;
      logic [7:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       gray_in_valid = 1'b0;
   logic [2:0] gray_in = 3'b000;
   logic [2:0] bin_out;
   logic       bin_valid;
   logic       locked;
   logic       seq_err;
   logic [7:0] err_count;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [2:0] last_b = 3'd0;
   logic       last_l = 1'b0;
   logic [7:0] last_c = 8'd0;

   gray_sequence_checker #(
      .WIDTH(3),
      .LOCK_CNT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gray_in_valid(gray_in_valid),
      .gray_in(gray_in),
      .bin_out(bin_out),
      .bin_valid(bin_valid),
      .locked(locked),
      .seq_err(seq_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic [2:0] g, input logic [2:0] eb,
                       input logic el, input logic ee);
      exp_t x;
      @(negedge clk);
      gray_in_valid = 1'b1;
      gray_in = g;
`ifdef GRAY_CHK_ERR_CNT_EN
      if (ee && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
      x.b = eb;
      x.l = el;
      x.e = ee;
      x.c = exp_cnt;
      sb_q.push_back(x);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         gray_in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      gap(2);
      chk("drain_before_rst", sb_q.size(), 0);
      #2 rst = 1'b1;
      #1;
      chk("rst_bin_out", bin_out, 0);
      chk("rst_bin_valid", bin_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_err_count", err_count, 0);
      last_b = 3'd0;
      last_l = 1'b0;
      last_c = 8'd0;
      exp_cnt = 8'd0;
      #1 rst = 1'b0;
   endtask

   // Monitor: pop on each output strobe, otherwise outputs must hold
   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (bin_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_bin_valid", 1, 0);
            end else begin
               x = sb_q.pop_front();
               chk("bin_out", bin_out, x.b);
               chk("locked", locked, x.l);
               chk("seq_err", seq_err, x.e);
               chk("err_count", err_count, x.c);
               last_b = x.b;
               last_l = x.l;
               last_c = x.c;
            end
         end else begin
            chk("hold_bin_out", bin_out, last_b);
            chk("hold_locked", locked, last_l);
            chk("hold_seq_err", seq_err, 0);
            chk("hold_err_count", err_count, last_c);
         end
      end
   end

   initial begin
      int budget;
      repeat (2) @(negedge clk);
      chk("init_bin_out", bin_out, 0);
      chk("init_bin_valid", bin_valid, 0);
      chk("init_locked", locked, 0);
      chk("init_err_count", err_count, 0);
      #2 rst = 1'b0;

      // acquire and lock
      send(3'b000, 3'd0, 1'b0, 1'b0);
      send(3'b001, 3'd1, 1'b0, 1'b0);
      send(3'b011, 3'd2, 1'b1, 1'b0);
      send(3'b010, 3'd3, 1'b1, 1'b0);
      send(3'b110, 3'd4, 1'b1, 1'b0);
      send(3'b111, 3'd5, 1'b1, 1'b0);
      // wrap-around stays locked
      send(3'b101, 3'd6, 1'b1, 1'b0);
      send(3'b100, 3'd7, 1'b1, 1'b0);
      send(3'b000, 3'd0, 1'b1, 1'b0);
      send(3'b001, 3'd1, 1'b1, 1'b0);
      send(3'b011, 3'd2, 1'b1, 1'b0);
      // skip from 2 to 4 breaks lock, then relock
      send(3'b110, 3'd4, 1'b0, 1'b1);
      send(3'b111, 3'd5, 1'b0, 1'b0);
      send(3'b101, 3'd6, 1'b1, 1'b0);

      // reset mid-lock, next sample is a fresh reference
      do_reset();
      send(3'b010, 3'd3, 1'b0, 1'b0);
      send(3'b110, 3'd4, 1'b0, 1'b0);
      send(3'b111, 3'd5, 1'b1, 1'b0);

      // samples separated by idle gaps
      do_reset();
      send(3'b000, 3'd0, 1'b0, 1'b0);
      gap(3);
      send(3'b001, 3'd1, 1'b0, 1'b0);
      gap(3);
      send(3'b011, 3'd2, 1'b1, 1'b0);
      gap(3);

      // repeated forced errors with relock in between
      send(3'b010, 3'd3, 1'b1, 1'b0);
      send(3'b110, 3'd4, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         send(3'b011, 3'd2, 1'b0, 1'b1);
         send(3'b010, 3'd3, 1'b0, 1'b0);
         send(3'b110, 3'd4, 1'b1, 1'b0);
      end
      gap(2);

      budget = 0;
      while (sb_q.size() != 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("scoreboard_empty", sb_q.size(), 0);
`ifdef GRAY_CHK_ERR_CNT_EN
      chk("final_err_count", err_count, 255);
`else
      chk("final_err_count", err_count, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
